// File: rtl/cell_packer_pkg.sv
// cell_packer_pkg
//   Shared definitions for the cell packer: FSM state encoding, frame
//   pointer field layout, word/cell geometry and two small helpers used
//   to build data words and pointer entries.
package cell_packer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DATA  = 3'd1,
      ST_TRUNC = 3'd2,
      ST_DROP  = 3'd3,
      ST_PTR   = 3'd4
   } state_t;

   // Frame pointer layout: {4'b0, portmap[3:0], word_count[7:0]}
   localparam int PTR_PORTMAP_LSB = 8;
   localparam int PTR_WCNT_W      = 8;

   localparam int BYTES_PER_WORD  = 16;
   localparam int BYTES_PER_CELL  = 64;
   localparam int WORD_W          = 8 * BYTES_PER_WORD;

   // Build a pointer FIFO entry from the latched portmap and word count.
   function automatic logic [15:0] make_ptr(input logic [3:0] portmap,
                                            input logic [PTR_WCNT_W-1:0] wcnt);
      logic [15:0] p;
      p = 16'h0000;
      p[PTR_PORTMAP_LSB +: 4] = portmap;
      p[PTR_WCNT_W-1:0]       = wcnt;
      return p;
   endfunction

   // Place a byte into lane idx of a word; lane 0 occupies the MSBs, so the
   // shift distance is (15 - idx) * 8, which for a 4-bit idx is {~idx, 3'b000}.
   function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] word,
                                                  input logic [3:0] idx,
                                                  input logic [7:0] data);
      logic [6:0]        sh;
      logic [WORD_W-1:0] mask;
      sh   = {~idx, 3'b000};
      mask = {{(WORD_W-8){1'b0}}, 8'hFF} << sh;
      return (word & ~mask) | ({{(WORD_W-8){1'b0}}, data} << sh);
   endfunction

endpackage

// File: rtl/cell_packer_sat_counter.sv
// cell_packer_sat_counter
//   Registered saturating event counter: increments by one on each cycle
//   with inc high and holds at all-ones.
// Ports:
//   clk   - system clock
//   rstn  - asynchronous active-low reset (count cleared)
//   inc   - count one event this cycle
//   count - current count
module cell_packer_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_r;

   // Counter register with saturation at all-ones.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_r <= {W{1'b0}};
      end else if (inc && (count_r != {W{1'b1}})) begin
         count_r <= count_r + W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/cell_packer.sv
// cell_packer
//   Packs a byte-wide, portmap-tagged frame stream into 128-bit words for
//   the switch core's cell data FIFO and emits one 16-bit frame pointer
//   per forwarded frame. Frames with an empty portmap are dropped, frames
//   longer than MAX_WORDS words are truncated (tail bytes swallowed).
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   i_data/i_valid       - frame byte and its valid
//   i_sof/i_eof          - first/last byte markers; i_sof qualifies i_portmap
//   i_portmap            - destination bitmap, sampled with i_sof
//   i_ready              - byte accepted when i_valid && i_ready
//   cell_data_fifo_din/wr- packed word (byte 0 in [127:120]) and write strobe
//   cell_ptr_fifo_din/wr - {4'b0, portmap, word_count} and write strobe
//   cell_bp              - core backpressure
//   o_drop_cnt           - frames dropped for empty portmap (saturating)
//   o_trunc_cnt          - frames truncated at MAX_WORDS (saturating)
module cell_packer
   import cell_packer_pkg::*;
#(
   parameter int MAX_WORDS = 96,
   parameter int CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [7:0]         i_data,
   input  logic               i_valid,
   input  logic               i_sof,
   input  logic               i_eof,
   input  logic [3:0]         i_portmap,
   output logic               i_ready,
   output logic [127:0]       cell_data_fifo_din,
   output logic               cell_data_fifo_wr,
   output logic [15:0]        cell_ptr_fifo_din,
   output logic               cell_ptr_fifo_wr,
   input  logic               cell_bp,
   output logic [CNT_W-1:0]   o_drop_cnt,
   output logic [CNT_W-1:0]   o_trunc_cnt
);

   localparam logic [7:0] MAX_W = 8'(MAX_WORDS);
   localparam logic [WORD_W-1:0] ZERO_WORD = {WORD_W{1'b0}};

   state_t              state_r, state_nxt;
   logic [3:0]          portmap_r, portmap_nxt;
   logic [3:0]          byte_idx_r, byte_idx_nxt;
   logic [7:0]          word_cnt_r, word_cnt_nxt;
   logic [WORD_W-1:0]   word_r, word_nxt;
   logic [WORD_W-1:0]   data_din_r, data_din_nxt;
   logic                data_wr_r, data_wr_nxt;
   logic [15:0]         ptr_din_r, ptr_din_nxt;
   logic                ptr_wr_r, ptr_wr_nxt;
   logic                ready_r, ready_nxt;
   logic                drop_inc_s, trunc_inc_s;
   logic                accept_s;
   logic [WORD_W-1:0]   lane_word_s;
   logic [WORD_W-1:0]   first_word_s;

   assign accept_s     = i_valid && ready_r;
   assign lane_word_s  = put_lane(word_r, byte_idx_r, i_data);
   assign first_word_s = put_lane(ZERO_WORD, 4'd0, i_data);

   // Next-state, datapath and output-strobe decode for the packer FSM.
   always_comb begin
      state_nxt    = state_r;
      portmap_nxt  = portmap_r;
      byte_idx_nxt = byte_idx_r;
      word_cnt_nxt = word_cnt_r;
      word_nxt     = word_r;
      data_din_nxt = data_din_r;
      data_wr_nxt  = 1'b0;
      ptr_din_nxt  = ptr_din_r;
      ptr_wr_nxt   = 1'b0;
      drop_inc_s   = 1'b0;
      trunc_inc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s && i_sof) begin
               portmap_nxt  = i_portmap;
               byte_idx_nxt = 4'd0;
               word_cnt_nxt = 8'd0;
               word_nxt     = ZERO_WORD;
               if (i_portmap == 4'b0000) begin
                  drop_inc_s = 1'b1;
                  // A single-byte empty-portmap frame is already complete.
                  state_nxt  = i_eof ? ST_IDLE : ST_DROP;
               end else if (i_eof) begin
                  data_din_nxt = first_word_s;
                  data_wr_nxt  = 1'b1;
                  word_cnt_nxt = 8'd1;
                  state_nxt    = ST_PTR;
               end else begin
                  word_nxt     = first_word_s;
                  byte_idx_nxt = 4'd1;
                  state_nxt    = ST_DATA;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               if (i_eof || (byte_idx_r == 4'd15)) begin
                  data_din_nxt = lane_word_s;
                  data_wr_nxt  = 1'b1;
                  word_nxt     = ZERO_WORD;
                  byte_idx_nxt = 4'd0;
                  word_cnt_nxt = word_cnt_r + 8'd1;
                  if (i_eof) begin
                     state_nxt = ST_PTR;
                  end else if ((word_cnt_r + 8'd1) == MAX_W) begin
                     trunc_inc_s = 1'b1;
                     state_nxt   = ST_TRUNC;
                  end else begin
                     state_nxt = ST_DATA;
                  end
               end else begin
                  word_nxt     = lane_word_s;
                  byte_idx_nxt = byte_idx_r + 4'd1;
               end
            end else begin
               state_nxt = ST_DATA;
            end
         end
         ST_TRUNC: begin
            if (accept_s && i_eof) begin
               state_nxt = ST_PTR;
            end else begin
               state_nxt = ST_TRUNC;
            end
         end
         ST_DROP: begin
            if (accept_s && i_eof) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DROP;
            end
         end
         ST_PTR: begin
            if (!cell_bp) begin
               ptr_din_nxt = make_ptr(portmap_r, word_cnt_r);
               ptr_wr_nxt  = 1'b1;
               state_nxt   = ST_IDLE;
            end else begin
               state_nxt = ST_PTR;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Ready for the coming cycle, derived from the state being entered.
   always_comb begin
      ready_nxt = 1'b0;
      case (state_nxt)
         ST_IDLE, ST_DATA: ready_nxt = !cell_bp;
         ST_TRUNC, ST_DROP: ready_nxt = 1'b1;
         ST_PTR:           ready_nxt = 1'b0;
         default:          ready_nxt = 1'b0;
      endcase
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= ST_IDLE;
         portmap_r  <= 4'b0000;
         byte_idx_r <= 4'd0;
         word_cnt_r <= 8'd0;
         word_r     <= ZERO_WORD;
         data_din_r <= ZERO_WORD;
         data_wr_r  <= 1'b0;
         ptr_din_r  <= 16'h0000;
         ptr_wr_r   <= 1'b0;
         ready_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         portmap_r  <= portmap_nxt;
         byte_idx_r <= byte_idx_nxt;
         word_cnt_r <= word_cnt_nxt;
         word_r     <= word_nxt;
         data_din_r <= data_din_nxt;
         data_wr_r  <= data_wr_nxt;
         ptr_din_r  <= ptr_din_nxt;
         ptr_wr_r   <= ptr_wr_nxt;
         ready_r    <= ready_nxt;
      end
   end

   cell_packer_sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (drop_inc_s),
      .count (o_drop_cnt)
   );

   cell_packer_sat_counter #(.W(CNT_W)) u_trunc_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (trunc_inc_s),
      .count (o_trunc_cnt)
   );

   assign i_ready            = ready_r;
   assign cell_data_fifo_din = data_din_r;
   assign cell_data_fifo_wr  = data_wr_r;
   assign cell_ptr_fifo_din  = ptr_din_r;
   assign cell_ptr_fifo_wr   = ptr_wr_r;

endmodule

// File: tb/tb_cell_packer.sv
// tb_cell_packer
//   Self-checking bench for cell_packer. Frames are built as byte arrays,
//   the expected word list and pointer are computed from the framing rules
//   (16 bytes per word, zero-padded tail, capped at MAX_WORDS), and the
//   FIFO writes captured by a monitor are compared against them.
module tb_cell_packer;

   localparam int MAX_WORDS = 96;
   localparam int CNT_W     = 16;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [7:0]        i_data = 8'h00;
   logic              i_valid = 1'b0;
   logic              i_sof = 1'b0;
   logic              i_eof = 1'b0;
   logic [3:0]        i_portmap = 4'h0;
   logic              i_ready;
   logic [127:0]      cell_data_fifo_din;
   logic              cell_data_fifo_wr;
   logic [15:0]       cell_ptr_fifo_din;
   logic              cell_ptr_fifo_wr;
   logic              cell_bp = 1'b0;
   logic [CNT_W-1:0]  o_drop_cnt;
   logic [CNT_W-1:0]  o_trunc_cnt;

   cell_packer #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .i_data             (i_data),
      .i_valid            (i_valid),
      .i_sof              (i_sof),
      .i_eof              (i_eof),
      .i_portmap          (i_portmap),
      .i_ready            (i_ready),
      .cell_data_fifo_din (cell_data_fifo_din),
      .cell_data_fifo_wr  (cell_data_fifo_wr),
      .cell_ptr_fifo_din  (cell_ptr_fifo_din),
      .cell_ptr_fifo_wr   (cell_ptr_fifo_wr),
      .cell_bp            (cell_bp),
      .o_drop_cnt         (o_drop_cnt),
      .o_trunc_cnt        (o_trunc_cnt)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int failed = 0;
   int cyc = 0;
   int bytes_acc = 0;
   int stall_cnt = 0;
   int exp_drop = 0;
   int exp_trunc = 0;
   int ptr_cyc = -1;
   int last_data_cyc = -1;
   logic bp_q = 1'b0;
   logic bp_chk = 1'b0;
   logic [127:0] got_data[$];
   logic [15:0]  got_ptr[$];

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      bp_q <= cell_bp;
   end

   // Monitor: capture FIFO writes, check pointer ordering and bp response.
   always @(negedge clk) begin
      if (rstn) begin
         if (cell_ptr_fifo_wr) begin
            compared++;
            if (cell_data_fifo_wr || (last_data_cyc >= cyc)) begin
               failed++;
               $display("FAIL ptr_order: ptr write at cycle %0d, last data write at cycle %0d, required strictly later",
                        cyc, last_data_cyc);
            end
            got_ptr.push_back(cell_ptr_fifo_din);
            ptr_cyc = cyc;
         end
         if (cell_data_fifo_wr) begin
            got_data.push_back(cell_data_fifo_din);
            last_data_cyc = cyc;
         end
         if (bp_chk && bp_q) begin
            compared++;
            if (i_ready || cell_ptr_fifo_wr) begin
               failed++;
               $display("FAIL bp_hold: i_ready=%0b ptr_wr=%0b during backpressure, required 0/0",
                        i_ready, cell_ptr_fifo_wr);
            end
         end
      end
   end

   // Present one byte (called at a negedge); returns at the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b, input logic sof, input logic eof,
                            input logic [3:0] pm);
      int n;
      n = 0;
      i_valid = 1'b1; i_data = b; i_sof = sof; i_eof = eof; i_portmap = pm;
      while (!i_ready && n < 2000) begin
         @(negedge clk);
         n++;
         stall_cnt++;
      end
      if (n >= 2000) begin
         compared++;
         failed++;
         $display("FAIL send_timeout: i_ready=0 for %0d cycles, required 1", n);
      end
      @(negedge clk);
      bytes_acc++;
      i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
   endtask

   // Send one frame and compare its FIFO writes against the framing model.
   task automatic run_frame(input string name, input int len, input logic [3:0] pm,
                            input bit incr, input int base, input int gap_pct,
                            input int ptr_bp, input bit chk_lat);
      logic [7:0]   bytes[$];
      logic [127:0] exp_w[$];
      logic [127:0] w;
      logic [15:0]  exp_ptr;
      int nw, n, e_cyc, exp_nptr, total_w;
      bit trunc;
      for (int i = 0; i < len; i++)
         bytes.push_back(incr ? 8'(base + i) : 8'($urandom_range(255)));
      total_w  = (len + 15) / 16;
      trunc    = (pm != 4'h0) && (total_w > MAX_WORDS);
      nw       = (pm == 4'h0) ? 0 : ((total_w > MAX_WORDS) ? MAX_WORDS : total_w);
      exp_nptr = (pm == 4'h0) ? 0 : 1;
      for (int k = 0; k < nw; k++) begin
         w = 128'd0;
         for (int j = 0; j < 16; j++)
            if (k * 16 + j < len) w[127 - 8 * j -: 8] = bytes[k * 16 + j];
         exp_w.push_back(w);
      end
      exp_ptr = {4'b0000, pm, 8'(nw)};
      if (pm == 4'h0) exp_drop++;
      if (trunc) exp_trunc++;
      got_data.delete();
      got_ptr.delete();
      for (int i = 0; i < len; i++) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            i_valid = 1'b0;
            @(negedge clk);
         end
         send_byte(bytes[i], (i == 0), (i == len - 1), pm);
      end
      e_cyc = cyc;
      if (ptr_bp > 0) cell_bp = 1'b1;
      n = 0;
      if (exp_nptr == 1) begin
         while (got_ptr.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (n == ptr_bp) cell_bp = 1'b0;
         end
      end
      cell_bp = 1'b0;
      repeat (10) @(negedge clk);
      compared++;
      if (got_data.size() != nw) begin
         failed++;
         $display("FAIL %s word_count: got %0d data writes, required %0d", name, got_data.size(), nw);
      end
      for (int k = 0; k < nw && k < got_data.size(); k++) begin
         compared++;
         if (got_data[k] !== exp_w[k]) begin
            failed++;
            $display("FAIL %s word[%0d]: got %h required %h", name, k, got_data[k], exp_w[k]);
         end
      end
      compared++;
      if (got_ptr.size() != exp_nptr) begin
         failed++;
         $display("FAIL %s ptr_count: got %0d ptr writes, required %0d", name, got_ptr.size(), exp_nptr);
      end
      if (exp_nptr == 1 && got_ptr.size() >= 1) begin
         compared++;
         if (got_ptr[0] !== exp_ptr) begin
            failed++;
            $display("FAIL %s ptr_value: got %h required %h", name, got_ptr[0], exp_ptr);
         end
         if (chk_lat) begin
            compared++;
            if (ptr_cyc != e_cyc + 1) begin
               failed++;
               $display("FAIL %s ptr_latency: ptr at +%0d cycles after eof, required +1", name, ptr_cyc - e_cyc);
            end
            if (!trunc) begin
               compared++;
               if (last_data_cyc != e_cyc) begin
                  failed++;
                  $display("FAIL %s data_latency: last data at +%0d cycles after eof, required +0",
                           name, last_data_cyc - e_cyc);
               end
            end
         end
         if (ptr_bp > 0) begin
            compared++;
            if (ptr_cyc != e_cyc + ptr_bp + 1) begin
               failed++;
               $display("FAIL %s ptr_after_bp: ptr at +%0d cycles after eof, required +%0d",
                        name, ptr_cyc - e_cyc, ptr_bp + 1);
            end
         end
      end
      compared++;
      if (o_drop_cnt !== CNT_W'(exp_drop)) begin
         failed++;
         $display("FAIL %s drop_cnt: got %0d required %0d", name, o_drop_cnt, exp_drop);
      end
      compared++;
      if (o_trunc_cnt !== CNT_W'(exp_trunc)) begin
         failed++;
         $display("FAIL %s trunc_cnt: got %0d required %0d", name, o_trunc_cnt, exp_trunc);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      compared++;
      if (i_ready !== 1'b0 || cell_data_fifo_wr !== 1'b0 || cell_ptr_fifo_wr !== 1'b0 ||
          cell_data_fifo_din !== 128'd0 || cell_ptr_fifo_din !== 16'h0000 ||
          o_drop_cnt !== CNT_W'(0) || o_trunc_cnt !== CNT_W'(0)) begin
         failed++;
         $display("FAIL %s outputs: rdy=%0b dwr=%0b pwr=%0b ddin=%h pdin=%h drop=%0d trunc=%0d, required all 0",
                  name, i_ready, cell_data_fifo_wr, cell_ptr_fifo_wr, cell_data_fifo_din,
                  cell_ptr_fifo_din, o_drop_cnt, o_trunc_cnt);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (i_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_ready: i_ready=%0b after reset release, required 1", i_ready);
      end
   endtask

   task automatic test_basic();
      run_frame("frame64", 64, 4'b0010, 1'b1, 0, 0, 0, 1'b1);
      run_frame("frame1", 1, 4'b1001, 1'b1, 8'hAB, 0, 0, 1'b1);
      run_frame("frame1518", 1518, 4'b0001, 1'b0, 0, 0, 0, 1'b1);
   endtask

   task automatic test_drop();
      run_frame("drop100", 100, 4'b0000, 1'b0, 0, 0, 0, 1'b0);
      run_frame("after_drop", 20, 4'b0100, 1'b0, 0, 0, 0, 1'b1);
   endtask

   task automatic test_trunc();
      stall_cnt = 0;
      run_frame("trunc2000", 2000, 4'b0001, 1'b0, 0, 0, 0, 1'b1);
      compared++;
      if (stall_cnt != 0) begin
         failed++;
         $display("FAIL trunc_ready: %0d stalled cycles without backpressure, required 0", stall_cnt);
      end
   endtask

   task automatic test_backpressure();
      bytes_acc = 0;
      bp_chk = 1'b1;
      fork
         run_frame("bp", 300, 4'b0110, 1'b0, 0, 0, 50, 1'b0);
         begin
            while (bytes_acc < 100) @(negedge clk);
            cell_bp = 1'b1;
            repeat (50) @(negedge clk);
            cell_bp = 1'b0;
         end
      join
      bp_chk = 1'b0;
   endtask

   task automatic test_random();
      int len;
      logic [3:0] pm;
      for (int f = 0; f < 8; f++) begin
         // Stray bytes without i_sof in IDLE must be ignored.
         for (int s = 0; s < 3; s++)
            send_byte(8'($urandom_range(255)), 1'b0, (s == 2), 4'($urandom_range(15)));
         len = (f % 4 == 3) ? int'($urandom_range(1540, 1800)) : int'($urandom_range(1, 400));
         pm  = 4'($urandom_range(15));
         run_frame("random", len, pm, 1'b0, 0, 25, 0, 1'b1);
      end
   endtask

   task automatic test_reset_mid();
      got_data.delete();
      got_ptr.delete();
      for (int i = 0; i < 40; i++)
         send_byte(8'(i + 1), (i == 0), 1'b0, 4'b0011);
      rstn = 1'b0;
      #1;
      check_outputs_zero("reset_mid");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      compared++;
      if (got_ptr.size() != 0) begin
         failed++;
         $display("FAIL reset_mid_ptr: got %0d ptr writes for aborted frame, required 0", got_ptr.size());
      end
      compared++;
      if (got_data.size() != 2) begin
         failed++;
         $display("FAIL reset_mid_data: got %0d data writes, required 2", got_data.size());
      end
      exp_drop  = 0;
      exp_trunc = 0;
      run_frame("post_reset", 33, 4'b1100, 1'b0, 0, 0, 0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_trunc();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
